// File: rtl/sdram_port_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : arbiter_pkg                                                    |
// | Purpose : Shared types for the two-master SDRAM port arbiter: the grant  |
// |           FSM state encoding and the master IDs stored in the read-tag   |
// |           FIFO.                                                          |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  localparam logic M0 = 1'b0;  // VGA frame reader
  localparam logic M1 = 1'b1;  // exponent accelerator

endpackage
`default_nettype wire

// File: rtl/sdram_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : sdram_port_arbiter_if                                        |
// | Purpose   : Avalon-MM style bundle for the arbiter: m0 (read-only VGA    |
// |             reader), m1 (read/write accelerator) and the SDRAM           |
// |             controller side (s_*).                                       |
// | Modports  : slave  - the arbiter itself (serves m0/m1, drives s_*)       |
// |             master - the environment (drives m0/m1, models the SDRAM)    |
// | Rev       : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0]   m0_address;
  logic                m0_read;
  logic                m0_waitrequest;
  logic [DATA_W-1:0]   m0_readdata;
  logic                m0_readdatavalid;

  logic [ADDR_W-1:0]   m1_address;
  logic                m1_read;
  logic                m1_write;
  logic [DATA_W-1:0]   m1_writedata;
  logic [DATA_W/8-1:0] m1_byteenable;
  logic                m1_waitrequest;
  logic [DATA_W-1:0]   m1_readdata;
  logic                m1_readdatavalid;

  logic [ADDR_W-1:0]   s_address;
  logic                s_read;
  logic                s_write;
  logic [DATA_W-1:0]   s_writedata;
  logic [DATA_W/8-1:0] s_byteenable;
  logic                s_waitrequest;
  logic [DATA_W-1:0]   s_readdata;
  logic                s_readdatavalid;

  modport slave (
    input  m0_address, m0_read,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output s_address, s_read, s_write, s_writedata, s_byteenable,
    input  s_waitrequest, s_readdata, s_readdatavalid
  );

  modport master (
    output m0_address, m0_read,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  s_address, s_read, s_write, s_writedata, s_byteenable,
    output s_waitrequest, s_readdata, s_readdatavalid
  );

endinterface
`default_nettype wire

// File: rtl/sdram_port_arbiter_tag_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : arb_tag_fifo                                                   |
// | Purpose : Small FIFO of master IDs for reads in flight. Head is visible  |
// |           combinationally so a return can be steered in its own cycle.   |
// | Ports   : clk, rst_n (async, active-low), push/push_data, pop,           |
// |           head, empty, count                                             |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module arb_tag_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 1,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_do_push = push && (r_count != CNT_W'(DEPTH));
  assign w_do_pop  = pop && (r_count != '0);
  assign head      = r_mem[r_rd_ptr];
  assign empty     = (r_count == '0);
  assign count     = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sdram_port_arbiter                                             |
// | Purpose : Shares one SDRAM controller port between m0 (VGA reader) and   |
// |           m1 (exponent accelerator). Grant FSM with burst limit and m1   |
// |           starvation guard; read returns steered by a tag FIFO.          |
// | Ports   : clk_clk, reset_reset_n (async, active-low),                    |
// |           bus (sdram_port_arbiter_if.slave: m0_*, m1_*, s_*)             |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module sdram_port_arbiter
  import arbiter_pkg::*;
#(
  parameter int ADDR_W       = 25,
  parameter int DATA_W       = 16,
  parameter int MAX_PEND     = 8,
  parameter int BURST_MAX    = 16,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  sdram_port_arbiter_if.slave bus
);

  localparam int CNT_W    = $clog2(MAX_PEND + 1);
  localparam int BURST_W  = $clog2(BURST_MAX + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t          r_state;
  logic [STARVE_W-1:0] r_starve;
  logic [BURST_W-1:0]  r_burst;
  logic                r_yield1;

  logic                w_m0_req, w_m1_req, w_m1_rd;
  logic                w_room, w_acc0, w_acc1, w_acc, w_push, w_pop;
  logic                w_head, w_empty;
  logic [CNT_W-1:0]    w_count;
  logic [BURST_W:0]    w_burst_next;
  logic                w_burst_done, w_starved, w_idle_to_g1;

  assign w_m0_req = bus.m0_read;
  assign w_m1_req = bus.m1_read | bus.m1_write;
  // A simultaneous m1 read+write is treated as a write so s_read/s_write never overlap.
  assign w_m1_rd  = bus.m1_read & ~bus.m1_write;
  assign w_room   = (w_count < CNT_W'(MAX_PEND));

  assign w_acc0 = (r_state == GRANT0) && bus.m0_read && !bus.s_waitrequest && w_room;
  assign w_acc1 = (r_state == GRANT1) && !bus.s_waitrequest &&
                  (bus.m1_write || (w_m1_rd && w_room));
  assign w_acc  = w_acc0 | w_acc1;
  assign w_push = w_acc0 | (w_acc1 & w_m1_rd);
  assign w_pop  = bus.s_readdatavalid & ~w_empty;

  assign bus.m0_waitrequest   = ~w_acc0;
  assign bus.m1_waitrequest   = ~w_acc1;
  assign bus.m0_readdata      = bus.s_readdata;
  assign bus.m1_readdata      = bus.s_readdata;
  assign bus.m0_readdatavalid = w_pop & (w_head == M0);
  assign bus.m1_readdatavalid = w_pop & (w_head == M1);

  assign w_burst_next = {1'b0, r_burst} + {{BURST_W{1'b0}}, w_acc};
  assign w_burst_done = (w_burst_next >= (BURST_W + 1)'(BURST_MAX));
  assign w_starved    = (r_starve == STARVE_W'(STARVE_LIMIT));
  // r_yield1 hands m1 the next grant after m0 was cut off by the burst
  // limit; otherwise m0's default priority would immediately re-win.
  assign w_idle_to_g1 = w_m1_req && (w_starved || r_yield1 || !w_m0_req);

  // Slave-side command is a combinational mirror of the granted master.
  always_comb begin
    bus.s_address    = '0;
    bus.s_read       = 1'b0;
    bus.s_write      = 1'b0;
    bus.s_writedata  = '0;
    bus.s_byteenable = '0;
    case (r_state)
      GRANT0: begin
        bus.s_address    = bus.m0_address;
        bus.s_read       = bus.m0_read & w_room;
        bus.s_byteenable = '1;
      end
      GRANT1: begin
        bus.s_address    = bus.m1_address;
        bus.s_read       = w_m1_rd & w_room;
        bus.s_write      = bus.m1_write;
        bus.s_writedata  = bus.m1_writedata;
        bus.s_byteenable = bus.m1_byteenable;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state  <= IDLE;
      r_starve <= '0;
      r_burst  <= '0;
      r_yield1 <= 1'b0;
    end else begin
      if (r_state == IDLE && w_idle_to_g1)
        r_starve <= '0;
      else if (w_m1_req && r_state != GRANT1 && !w_starved)
        r_starve <= r_starve + 1'b1;

      case (r_state)
        IDLE: begin
          r_burst  <= '0;
          r_yield1 <= 1'b0;
          if (w_idle_to_g1)  r_state <= GRANT1;
          else if (w_m0_req) r_state <= GRANT0;
        end
        GRANT0: begin
          r_burst <= w_burst_done ? BURST_W'(BURST_MAX) : w_burst_next[BURST_W-1:0];
          if (!w_m0_req || (w_burst_done && w_m1_req)) begin
            r_state  <= IDLE;
            r_yield1 <= w_burst_done && w_m1_req;
          end
        end
        GRANT1: begin
          r_burst <= w_burst_done ? BURST_W'(BURST_MAX) : w_burst_next[BURST_W-1:0];
          if (!w_m1_req || (w_burst_done && w_m0_req)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  arb_tag_fifo #(
    .DEPTH (MAX_PEND),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (w_push),
    .push_data (r_state == GRANT1 ? M1 : M0),
    .pop       (w_pop),
    .head      (w_head),
    .empty     (w_empty),
    .count     (w_count)
  );

endmodule
`default_nettype wire
